// File: rtl/npu_pkg.sv
// Shared constants and types for the NPU neuron datapath.
// Optional build macro used by the neuron MAC: NEURON_RELU_EN.
package npu_pkg;

    localparam int IMG_DEPTH  = 784;
    localparam int PIX_W      = 8;
    localparam int WGT_W      = 8;
    localparam int ACC_W      = 26;
    localparam int IMG_ADDR_W = 10;

    // Unsigned pixel widened by one sign bit, times a signed weight.
    localparam int PROD_W = PIX_W + WGT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/npu_mac_stage.sv
// Registered signed pixel x weight multiplier with a product-valid flag.
// Reusable building block for single- and multi-neuron arrays.
module npu_mac_stage
    import npu_pkg::*;
#(
    parameter int PIX_BITS = PIX_W,
    parameter int WGT_BITS = WGT_W,
    parameter int PRD_BITS = PROD_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic                       i_clr,
    input  logic [PIX_BITS-1:0]        i_pixel,
    input  logic [WGT_BITS-1:0]        i_weight,
    output logic signed [PRD_BITS-1:0] o_prod,
    output logic                       o_valid
);

    logic signed [PRD_BITS-1:0] w_pix_s;
    logic signed [PRD_BITS-1:0] w_wgt_s;
    logic signed [PRD_BITS-1:0] r_prod;
    logic                       r_valid;

    // Pixel is zero-extended, weight is sign-extended, to product width.
    always_comb begin
        w_pix_s = PRD_BITS'($signed({1'b0, i_pixel}));
        w_wgt_s = PRD_BITS'($signed(i_weight));
    end

    // Product register; clear drops the valid flag without touching data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prod  <= '0;
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_prod  <= w_pix_s * w_wgt_s;
            r_valid <= 1'b1;
        end
    end

    assign o_prod  = r_prod;
    assign o_valid = r_valid;

endmodule

// File: rtl/npu_neuron_mac.sv
// Single-neuron dot product over one image: sum(pixel*weight) + bias.
// Build macro NEURON_RELU_EN clamps a negative result to zero.
module npu_neuron_mac
    import npu_pkg::*;
#(
    parameter int BIT_DEPTH  = PIX_W,
    parameter int ADDR_WIDTH = IMG_ADDR_W,
    parameter int DEPTH      = IMG_DEPTH,
    parameter int ACC_WIDTH  = ACC_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic [ADDR_WIDTH-1:0]       rd_addr,
    input  logic [BIT_DEPTH-1:0]        pixel_in,
    input  logic [BIT_DEPTH-1:0]        weight_in,
    input  logic signed [ACC_WIDTH-1:0] bias_in,
    output logic                        busy,
    output logic                        done,
    output logic signed [ACC_WIDTH-1:0] acc_out
);

    localparam int PW = 2 * BIT_DEPTH + 1;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic [ADDR_WIDTH-1:0]       w_addr_nxt;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] w_acc_nxt;
    logic signed [ACC_WIDTH-1:0] r_acc_out;
    logic signed [ACC_WIDTH-1:0] w_acc_out_nxt;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] w_result;
    logic signed [PW-1:0]        w_prod;
    logic                        w_pvalid;
    logic                        r_busy;
    logic                        w_busy_nxt;
    logic                        r_done;
    logic                        w_done_nxt;
    logic                        w_mac_en;
    logic                        w_mac_clr;
    logic                        w_last;

    npu_mac_stage #(
        .PIX_BITS (BIT_DEPTH),
        .WGT_BITS (BIT_DEPTH),
        .PRD_BITS (PW)
    ) u_mac (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_en     (w_mac_en),
        .i_clr    (w_mac_clr),
        .i_pixel  (pixel_in),
        .i_weight (weight_in),
        .o_prod   (w_prod),
        .o_valid  (w_pvalid)
    );

    assign w_prod_ext = ACC_WIDTH'(w_prod);
    assign w_last     = (r_addr == ADDR_WIDTH'(DEPTH - 1));

`ifdef NEURON_RELU_EN
    assign w_result = r_acc[ACC_WIDTH-1] ? '0 : r_acc;
`else
    assign w_result = r_acc;
`endif

    // Next-state, address sweep and accumulate decisions.
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_acc_nxt     = r_acc;
        w_acc_out_nxt = r_acc_out;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_mac_en      = 1'b0;
        w_mac_clr     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_addr_nxt = '0;
                if (start) begin
                    w_acc_nxt   = bias_in;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_busy_nxt = 1'b0;
                end
            end
            RUN: begin
                w_mac_en = 1'b1;
                if (w_pvalid) begin
                    w_acc_nxt = r_acc + w_prod_ext;
                end
                if (w_last) begin
                    w_addr_nxt  = '0;
                    w_state_nxt = DRAIN;
                end else begin
                    w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                w_acc_nxt   = r_acc + w_prod_ext;
                w_mac_clr   = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                w_acc_out_nxt = w_result;
                w_done_nxt    = 1'b1;
                w_state_nxt   = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; busy drops in the idle cycle after done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_acc     <= '0;
            r_acc_out <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_acc     <= w_acc_nxt;
            r_acc_out <= w_acc_out_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign rd_addr = r_addr;
    assign busy    = r_busy;
    assign done    = r_done;
    assign acc_out = r_acc_out;

endmodule
